// File: rtl/dispatch.sv
// ----------------------------------------------------------------------------
// dispatch
//   A small FIFO that feeds a downstream accumulator in one of two modes:
//     stream : pop one word per cycle for as long as words are queued
//     burst  : on an i_go pulse, pop exactly the number of words held at that
//              moment, on consecutive cycles, and then stop
//   The popped word is registered, so o_data/o_valid follow the pop by one
//   cycle. o_data is forced to zero on every cycle that carries no word.
//
// Optional feature (macro DISPATCH_ZERO_DROP_EN):
//   When defined, a zero-valued input word completes its handshake but is
//   not stored. When undefined, zero words are queued like any other word.
//
// Ports
//   i_clk    : clock, all state on rising edge
//   i_rst_n  : synchronous active-low reset
//   i_mode   : 0 = stream, 1 = burst (sampled in IDLE only)
//   i_valid  : upstream word present
//   i_data   : upstream word (16 bits)
//   o_ready  : FIFO can accept (count < DEPTH), combinational
//   i_go     : burst start pulse, honoured only in IDLE in burst mode
//   o_data   : registered popped word, zero on idle cycles
//   o_valid  : registered, high when o_data carries a popped word
//   o_count  : current FIFO occupancy
//   o_busy   : high while in STREAM or BURST
// ----------------------------------------------------------------------------
module dispatch #(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_mode,
    input  logic                       i_valid,
    input  logic [15:0]                i_data,
    output logic                       o_ready,
    input  logic                       i_go,
    output logic [15:0]                o_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_BURST  = 2'd2;

    logic [1:0]    r_state;
    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_burst_len;   // words still to pop in the current burst
    logic [15:0]   r_o_data;
    logic          r_o_valid;

    logic [1:0]    w_next_state;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;

    assign o_ready = (r_count < COUNT_FULL);
    assign w_accept = i_valid && o_ready;

`ifdef DISPATCH_ZERO_DROP_EN
    // Zero words complete the handshake but never occupy a slot.
    assign w_push = w_accept && (i_data != 16'h0000);
`else
    assign w_push = w_accept;
`endif

    // The pop decision depends only on the current state; a transition out of
    // IDLE does not pop in the same cycle.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_STREAM: w_pop = (r_count != '0);
            S_BURST:  w_pop = (r_burst_len != '0);
            default:  w_pop = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    if (!i_mode)
                        w_next_state = S_STREAM;
                    else if (i_go)
                        w_next_state = S_BURST;
                end
            end
            S_STREAM: begin
                // Leave as soon as the last queued word goes with nothing
                // arriving to replace it.
                if (r_count == '0)
                    w_next_state = S_IDLE;
                else if (w_pop && (r_count == COUNT_ONE) && !w_push)
                    w_next_state = S_IDLE;
            end
            S_BURST: begin
                if (r_burst_len <= COUNT_ONE)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_burst_len <= '0;
            r_o_data    <= 16'h0000;
            r_o_valid   <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase

            // Snapshot the occupancy at the i_go cycle; words pushed later
            // stay queued for the next run.
            if (r_state == S_IDLE && w_next_state == S_BURST)
                r_burst_len <= r_count;
            else if (r_state == S_BURST && w_pop)
                r_burst_len <= r_burst_len - COUNT_ONE;

            r_o_valid <= w_pop;
            r_o_data  <= w_pop ? r_mem[r_rd_ptr] : 16'h0000;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone
    // decide which entries are meaningful, so stale contents are never read.
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_o_data;
    assign o_valid = r_o_valid;
    assign o_count = r_count;
    assign o_busy  = (r_state == S_STREAM) || (r_state == S_BURST);

endmodule

// File: tb/tb_dispatch.sv
// ----------------------------------------------------------------------------
// tb_dispatch
//   Self-checking bench for dispatch (DEPTH = 4). Accepted words are pushed
//   onto a scoreboard queue when driven; a negedge monitor pops and compares
//   every word the DUT emits. Directed checks cover reset state, stream
//   latency, full FIFO, burst snapshot, reset mid-burst, zero words and
//   pointer wrap. Honours DISPATCH_ZERO_DROP_EN for the zero-word case.
// ----------------------------------------------------------------------------
module tb_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic        valid;
    logic [15:0] data;
    logic        ready;
    logic        go;
    logic [15:0] out_data;
    logic        out_valid;
    logic [2:0]  count;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    logic [15:0] sb [$];

    dispatch #(.DEPTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_mode  (mode),
        .i_valid (valid),
        .i_data  (data),
        .o_ready (ready),
        .i_go    (go),
        .o_data  (out_data),
        .o_valid (out_valid),
        .o_count (count),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer: every emitted word must match the oldest expected.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid === 1'b1) begin
                if (sb.size() == 0)
                    check("spurious_out", 32'(out_data), 32'hdead);
                else
                    check("out_data", 32'(out_data), 32'(sb.pop_front()));
                n_out++;
            end else begin
                check("idle_data_zero", 32'(out_data), 32'h0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_stored(input logic [15:0] d);
`ifdef DISPATCH_ZERO_DROP_EN
        return d != 16'h0000;
`else
        return 1'b1;
`endif
    endfunction

    task automatic send(input logic [15:0] d, input bit exp_acc);
        check("ready", 32'(ready), 32'(exp_acc));
        valid = 1'b1;
        data  = d;
        step();
        valid = 1'b0;
        data  = 16'h0000;
        if (exp_acc && is_stored(d))
            sb.push_back(d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'h0);
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n = 1'b0; mode = 1'b0; valid = 1'b0; data = 16'h0; go = 1'b0;

        // Reset state
        do_reset();
        check("rst_ready", 32'(ready), 32'h1);
        check("rst_count", 32'(count), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data",  32'(out_data), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);

        // Stream: first word two cycles after its push, then idle
        mode = 1'b0;
        n0 = n_out;
        send(16'h0001, 1'b1);
        send(16'h0002, 1'b1);
        send(16'h0003, 1'b1);
        check("stream_first_valid", 32'(out_valid), 32'h1);
        check("stream_first_data",  32'(out_data), 32'h1);
        step(); step(); step();
        check("stream_end_valid", 32'(out_valid), 32'h0);
        check("stream_end_data",  32'(out_data), 32'h0);
        check("stream_end_busy",  32'(busy), 32'h0);
        check("stream_end_count", 32'(count), 32'h0);
        check("stream_nout", 32'(n_out - n0), 32'd3);

        // Full FIFO in burst mode; i_go with empty FIFO is ignored
        do_reset();
        mode = 1'b1;
        go = 1'b1; step(); go = 1'b0;
        check("go_empty_busy", 32'(busy), 32'h0);
        n0 = n_out;
        send(16'h0101, 1'b1);
        send(16'h0102, 1'b1);
        send(16'h0103, 1'b1);
        send(16'h0104, 1'b1);
        check("full_count", 32'(count), 32'd4);
        check("full_busy",  32'(busy), 32'h0);
        send(16'h0105, 1'b0);
        check("full_count_after_reject", 32'(count), 32'd4);
        go = 1'b1; step(); go = 1'b0;
        check("burst_busy", 32'(busy), 32'h1);
        run_until_idle(20);
        check("full_nout", 32'(n_out - n0), 32'd4);
        check("full_drain_count", 32'(count), 32'h0);
        check("full_sb_empty", 32'(sb.size()), 32'h0);

        // Burst snapshot: word pushed during a burst stays queued
        do_reset();
        mode = 1'b1;
        n0 = n_out;
        send(16'h0201, 1'b1);
        send(16'h0202, 1'b1);
        go = 1'b1; step(); go = 1'b0;
        send(16'h00AA, 1'b1);
        run_until_idle(20);
        check("snap_nout", 32'(n_out - n0), 32'd2);
        check("snap_count", 32'(count), 32'd1);
        check("snap_busy", 32'(busy), 32'h0);
        check("snap_sb_left", 32'(sb.size()), 32'd1);
        mode = 1'b0;
        step();
        run_until_idle(20);
        check("snap_aa_out", 32'(n_out - n0), 32'd3);
        check("snap_sb_empty", 32'(sb.size()), 32'h0);

        // Reset mid-burst discards queued words
        do_reset();
        mode = 1'b1;
        send(16'h0301, 1'b1);
        send(16'h0302, 1'b1);
        send(16'h0303, 1'b1);
        go = 1'b1; step(); go = 1'b0;
        step();
        check("midrst_first_pop", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        step();
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_data",  32'(out_data), 32'h0);
        check("midrst_count", 32'(count), 32'h0);
        check("midrst_busy",  32'(busy), 32'h0);
        sb.delete();
        rst_n = 1'b1;
        n0 = n_out;
        repeat (6) step();
        check("midrst_no_out", 32'(n_out - n0), 32'h0);
        check("midrst_ready", 32'(ready), 32'h1);

        // Zero-valued word
        do_reset();
        mode = 1'b0;
        n0 = n_out;
        send(16'h0000, 1'b1);
        check("zero_count", 32'(count), is_stored(16'h0000) ? 32'd1 : 32'd0);
        step(); step();
        run_until_idle(20);
        check("zero_nout", 32'(n_out - n0), is_stored(16'h0000) ? 32'd1 : 32'd0);
        check("zero_sb_empty", 32'(sb.size()), 32'h0);

        // Pointer wrap: ten back-to-back words in stream mode
        do_reset();
        mode = 1'b0;
        n0 = n_out;
        for (int i = 0; i < 10; i++) begin
            send(16'h0010 + 16'(i), 1'b1);
            check("wrap_count_le2", 32'(count <= 3'd2), 32'h1);
        end
        step();
        run_until_idle(20);
        check("wrap_nout", 32'(n_out - n0), 32'd10);
        check("wrap_sb_empty", 32'(sb.size()), 32'h0);
        check("wrap_count_end", 32'(count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dispatch.md
DISPATCH -- requirements
Module: dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, >=2).
REQ-002 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_mode  input  1  0 = stream, 1 = burst; sampled only in IDLE.
REQ-005 SHALL have port i_valid  input  1  upstream word present.
REQ-006 SHALL have port i_data  input  16  upstream word.
REQ-007 SHALL have port o_ready  output  1  FIFO can accept; combinational, equals (count < DEPTH).
REQ-008 SHALL have port i_go  input  1  burst start pulse; ignored outside burst mode IDLE.
REQ-009 SHALL have port o_data  output  16  registered word to accumulator; 16'h0000 on idle cycles.
REQ-010 SHALL have port o_valid  output  1  registered, high when o_data carries a popped word.
REQ-011 SHALL have port o_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port o_busy  output  1  high in STREAM or BURST.

Function
REQ-013 SHALL push i_data when i_valid && o_ready at a clock edge; no push when full.
REQ-014 SHALL use FSM states IDLE, STREAM, BURST.
REQ-015 IDLE: i_mode=0 and count>0 -> STREAM; i_mode=1 and i_go and count>0 -> BURST; else stay.
REQ-016 STREAM SHALL pop one word per cycle while count>0; return to IDLE the cycle the FIFO becomes empty with no concurrent push.
REQ-017 BURST SHALL latch burst length = count at the i_go cycle, pop exactly that many words on consecutive cycles, then return to IDLE; words pushed during BURST remain queued.
REQ-018 SHALL register the popped word: o_data/o_valid update 1 cycle after the pop; non-pop cycles drive o_data=0, o_valid=0.
REQ-019 SHALL preserve FIFO order; read/write pointers wrap modulo DEPTH.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; allowed whenever count<DEPTH.
REQ-021 At count==DEPTH, o_ready=0; a pop in that cycle frees space visible next cycle only.
REQ-022 i_go in STREAM, in BURST, or with count==0 SHALL be ignored.
REQ-023 i_mode changes outside IDLE SHALL not affect the current STREAM/BURST run.
REQ-024 Zero-valued words SHALL be stored and popped normally (o_valid=1, o_data=0) unless REQ-029 applies.

Reset
REQ-025 While i_rst_n=0 at a rising edge: state=IDLE, pointers=0, count=0, o_data=0, o_valid=0, burst length=0.
REQ-026 Reset mid-STREAM/BURST SHALL discard all queued words; no output word after reset release until a new push.
REQ-027 o_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-028 SHALL recognise macro DISPATCH_ZERO_DROP_EN.
REQ-029 With DISPATCH_ZERO_DROP_EN defined: i_valid with i_data==0 SHALL be accepted (handshake completes when o_ready=1) but not stored; count unchanged.
REQ-030 Without DISPATCH_ZERO_DROP_EN: zero words SHALL be stored per REQ-024.

Verification
REQ-031 Stream: mode=0, push 0x0001,0x0002,0x0003 on consecutive cycles -> o_data 0x0001,0x0002,0x0003 with o_valid, first one 2 cycles after first push, then o_data=0, o_busy=0.
REQ-032 Full: mode=1, push 5 words with DEPTH=4 -> 5th rejected (o_ready=0), o_count=4; i_go -> 4 words out in order, o_count=0.
REQ-033 Burst snapshot: mode=1, 2 words queued, i_go, push 0x00AA during burst -> exactly 2 words out, IDLE, o_count=1 holding 0x00AA.
REQ-034 Reset mid-burst: 3 queued, i_go, assert i_rst_n=0 after first pop -> o_data=0, o_valid=0, o_count=0, IDLE.
REQ-035 Zero word: push 0x0000 -> without macro o_valid=1 with o_data=0; with DISPATCH_ZERO_DROP_EN, o_count stays 0 and no o_valid.
REQ-036 Pointer wrap: mode=0, push 10 words 0x0010..0x0019 back-to-back -> all 10 emitted in order, no loss, o_count never exceeds 2.
